// File: rtl/regfile.sv
// regfile: architectural integer register file for the RV32I core.
// One write-back port (fed from MEM/WB) and two combinational read ports
// for decode. Register x0 is hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a read of the
// register being written back in the same cycle returns the incoming data.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [NREG];

  logic wr_fire;

  // A write commits only when the pipeline is ready and the target is not x0.
  assign wr_fire = rdy && we && (waddr != '0);

  // Storage update: reset wipes every entry in one edge and wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port 1: reset, disable and x0 force zero; then bypass (if built in), then array.
  always_comb begin
    rdata1 = '0;
    if (rst || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
`endif
    end else begin
      rdata1 = mem[raddr1];
    end
  end

  // Read port 2: identical rules to port 1, evaluated independently.
  always_comb begin
    rdata2 = '0;
    if (rst || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
`endif
    end else begin
      rdata2 = mem[raddr2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vectors for regfile. Stimulus pushes the expected read
// data for each checked cycle into a queue; a monitor on the falling edge pops
// and compares against the combinational read ports.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } exp_t;

  exp_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: mid-cycle, compare both ports against the pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput({e.name, ".rdata1"}, rdata1, e.exp1);
      checkOutput({e.name, ".rdata2"}, rdata2, e.exp2);
    end
  end

  // Drive one cycle of inputs; optionally queue the expected read data for it.
  task automatic applyStimulus(
    input logic rst_v, input logic rdy_v,
    input logic we_v, input logic [4:0] wa, input logic [31:0] wd,
    input logic re1_v, input logic [4:0] ra1,
    input logic re2_v, input logic [4:0] ra2,
    input bit chk, input logic [31:0] e1, input logic [31:0] e2, input string nm);
    exp_t e;
    rst = rst_v; rdy = rdy_v; we = we_v; waddr = wa; wdata = wd;
    re1 = re1_v; raddr1 = ra1; re2 = re2_v; raddr2 = ra2;
    if (chk) begin
      e.name = nm; e.exp1 = e1; e.exp2 = e2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    @(posedge clk);
    #1;

    //             rst rdy we  wa     wdata          re1 ra1    re2 ra2   chk exp1           exp2
    applyStimulus(1, 1, 0, 5'd0,  32'h0,         1, 5'd5,  1, 5'd7,  1, 32'h0,         32'h0,        "reset_out");
    applyStimulus(0, 1, 1, 5'd5,  32'hDEADBEEF,  1, 5'd1,  1, 5'd2,  1, 32'h0,         32'h0,        "post_reset_zero");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd5,  1, 5'd5,  1, 32'hDEADBEEF,  32'hDEADBEEF, "load_x5");
    applyStimulus(1, 1, 0, 5'd0,  32'h0,         1, 5'd5,  1, 5'd5,  1, 32'h0,         32'h0,        "rst_read");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd5,  1, 5'd5,  1, 32'h0,         32'h0,        "reset_clears");
    applyStimulus(0, 1, 1, 5'd0,  32'h12345678,  1, 5'd0,  1, 5'd0,  1, 32'h0,         32'h0,        "x0_same");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd0,  1, 5'd0,  1, 32'h0,         32'h0,        "x0_next");
    applyStimulus(0, 1, 1, 5'd7,  32'h000000A5,  0, 5'd0,  0, 5'd0,  0, 32'h0,         32'h0,        "");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd7,  1, 5'd7,  1, 32'h000000A5,  32'h000000A5, "x7_both");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd7,  0, 5'd7,  1, 32'h000000A5,  32'h0,        "x7_re2_off");
    applyStimulus(0, 1, 1, 5'd3,  32'h11,        0, 5'd0,  0, 5'd0,  0, 32'h0,         32'h0,        "");
    applyStimulus(0, 1, 1, 5'd3,  32'h22,        1, 5'd3,  1, 5'd7,  1, BYP ? 32'h22 : 32'h11, 32'h000000A5, "hazard");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd3,  1, 5'd3,  1, 32'h22,        32'h22,       "hazard_next");

    // rdy gating: establish old x9, then hold a write while frozen.
    applyStimulus(0, 1, 1, 5'd9,  32'h44,        0, 5'd0,  0, 5'd0,  0, 32'h0,         32'h0,        "");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 5'd9, 32'h55,       1, 5'd9,  1, 5'd3,  1, BYP ? 32'h55 : 32'h44, 32'h22, "rdy_hold");
    end
    applyStimulus(0, 0, 0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd9,  1, 32'h44,        32'h44,       "rdy_frozen");
    applyStimulus(0, 1, 1, 5'd9,  32'h55,        1, 5'd9,  0, 5'd9,  1, BYP ? 32'h55 : 32'h44, 32'h0, "rdy_raise");
    applyStimulus(0, 1, 1, 5'd9,  32'h55,        1, 5'd9,  1, 5'd9,  1, 32'h55,        32'h55,       "rdy_idempotent");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd5,  1, 32'h55,        32'h0,        "rdy_release");

    // Reset over a concurrent write.
    applyStimulus(0, 1, 1, 5'd4,  32'h66,        0, 5'd0,  0, 5'd0,  0, 32'h0,         32'h0,        "");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd4,  1, 5'd9,  1, 32'h66,        32'h55,       "pre_rst_x4");
    applyStimulus(1, 1, 1, 5'd4,  32'h99,        1, 5'd4,  1, 5'd4,  1, 32'h0,         32'h0,        "rst_with_we");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd4,  1, 5'd9,  1, 32'h0,         32'h0,        "rst_over_write");

    // Top index boundary.
    applyStimulus(0, 1, 1, 5'd31, 32'hFFFFFFFF,  0, 5'd0,  0, 5'd0,  0, 32'h0,         32'h0,        "");
    applyStimulus(0, 1, 0, 5'd0,  32'h0,         1, 5'd31, 1, 5'd30, 1, 32'hFFFFFFFF,  32'h0,        "x31_boundary");

    applyStimulus(0, 1, 0, 5'd0,  32'h0,         0, 5'd0,  0, 5'd0,  0, 32'h0,         32'h0,        "");
    @(posedge clk);
    #1;

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file for the five-stage RV32I core; it receives the write-back stream (`rd` address, data, enable) produced by the MEM/WB pipeline register. It also serves the decode stage through two read ports. Register x0 is hardwired to zero. An optional write-to-read bypass lets decode see a value in the same cycle it is being written back.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: register index width.
- `NREG`, 32: number of registers, `2**ADDR_W`.

Ports:
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `rdy`, in, 1: global ready; when low, architectural state is frozen.
- `we`, in, 1: write-back enable, from `wb_rd_e`.
- `waddr`, in, `ADDR_W`: write-back destination, from `wb_rd_addr`.
- `wdata`, in, `DATA_W`: write-back data, from `wb_rd_data`.
- `re1`, in, 1: read enable, port 1 (rs1).
- `raddr1`, in, `ADDR_W`: read index, port 1.
- `rdata1`, out, `DATA_W`: read data, port 1; combinational.
- `re2`, in, 1: read enable, port 2 (rs2).
- `raddr2`, in, `ADDR_W`: read index, port 2.
- `rdata2`, out, `DATA_W`: read data, port 2; combinational.

## Operation
Storage is `NREG` entries of `DATA_W` bits. Entry 0 is never written.

Write, evaluated at each rising edge:
- `rst`=1: all entries are cleared to 0 in that single edge. Any `we` presented in the same cycle is discarded.
- Otherwise, `rdy`=1, `we`=1 and `waddr`≠0: entry[`waddr`] <= `wdata`.
- In every other case nothing changes. In particular, `we` with `waddr`=0 is silently dropped.

Read: each port is independent and uses identical rules. Priority, highest first:
1. `rst`=1 -> 0.
2. `reN`=0 -> 0.
3. `raddrN`=0 -> 0.
4. Bypass, only when compiled in (see Configuration): `we`=1 and `waddr`=`raddrN` -> `wdata`.
5. Otherwise -> entry[`raddrN`].

Both ports may read the same index in the same cycle; both return identical data. A read of an index being written in the same cycle returns the old entry unless the bypass is enabled. The bypass does not depend on `rdy`: a held write-back value is already committed and is forwarded regardless.

## Timing
- Write latency: 1 edge. Data is visible through the array on the cycle after the write edge.
- Read latency: 0 cycles, purely combinational from `reN`, `raddrN`, `we`, `waddr`, `wdata` and `rst`. No output registers.
- Reset values: `rdata1` and `rdata2` are 0 while `rst`=1; all entries are 0 from the first cycle after reset.
- Reset asserted mid-stream: any pending write in that cycle is lost. No partial state remains.
- `rdy` low for N cycles with `we` held: exactly one write happens, on the first edge where `rdy`=1. The write is idempotent if `we` stays high afterwards.
- No handshake and no backpressure. The block always accepts a write and never stalls.

## Configuration
- `REGFILE_BYPASS_EN` defined: read priority rule 4 is active. Decode obtains a value written back in the same cycle, which closes the WB->ID hazard without a stall.
- `REGFILE_BYPASS_EN` undefined: rule 4 is removed and a same-cycle read returns the pre-write entry. The hazard unit must then stall or forward one extra cycle.
- The macro changes no other behaviour, including x0 handling, reset and `rdy` gating.

## Test plan
- Reset clears the array: load entry 5 = 0xDEADBEEF, pulse `rst` for 1 cycle, then read `raddr1`=5 with `re1`=1 -> 0.
- x0 hardwired: write `waddr`=0, `wdata`=0x12345678 -> `rdata1` and `rdata2` at index 0 read 0, both in the same cycle and on the following cycle.
- Basic write then read: write x7 = 0x0000_00A5, then read x7 next cycle on both ports -> 0x000000A5 on both. With `re2`=0 -> `rdata2`=0.
- Same-cycle hazard: entry x3 = 0x11, then `we`=1, `waddr`=3, `wdata`=0x22 while `raddr1`=3.
  - With `REGFILE_BYPASS_EN` defined -> `rdata1`=0x22.
  - Without the macro -> `rdata1`=0x11.
  - In both builds, the next cycle -> 0x22.
- `rdy` gating: `rdy`=0 for 3 cycles with a write of x9 = 0x55 held -> x9 keeps its old value. Raising `rdy` -> x9 = 0x55 after one edge.
- Reset over write: `rst`=1 and `we`=1, `waddr`=4, `wdata`=0x99 in the same cycle -> x4 reads 0 afterwards.
